// File: rtl/pipe_pkg.sv
// Shared pipeline types: the EX/MEM control bundle and the payload word layout
// used by instantiators of pipe_stage_skid.
package pipe_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic [1:0] result_src;
    logic [4:0] rd;
  } exmem_ctrl_t;

  localparam int EXMEM_CTRL_W = $bits(exmem_ctrl_t);

  // Payload word slots, word 0 in the least-significant DATA_WIDTH bits.
  localparam int WORD_ALU    = 0;
  localparam int WORD_WDATA  = 1;
  localparam int WORD_PC4    = 2;
  localparam int EXMEM_WORDS = 3;

endpackage

// File: rtl/pipe_stage_skid.sv
// Generic ready/valid pipeline stage with a 2-entry skid buffer, synchronous
// flush, bubble control-zeroing and a saturating stall-cycle counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DATA_WORDS  = EXMEM_WORDS,
  parameter int CTRL_WIDTH  = EXMEM_CTRL_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CTRL_WIDTH-1:0]            in_ctrl,
  input  logic [DATA_WORDS*DATA_WIDTH-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic [DATA_WORDS*DATA_WIDTH-1:0] out_data,
  output logic [STALL_CNT_W-1:0]           stall_cnt
);

  localparam int                     PAYLOAD_W = DATA_WORDS * DATA_WIDTH;
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  logic                   main_v_q,    main_v_d;
  logic [CTRL_WIDTH-1:0]  main_ctrl_q, main_ctrl_d;
  logic [PAYLOAD_W-1:0]   main_data_q, main_data_d;
  logic                   skid_v_q,    skid_v_d;
  logic [CTRL_WIDTH-1:0]  skid_ctrl_q, skid_ctrl_d;
  logic [PAYLOAD_W-1:0]   skid_data_q, skid_data_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic accept;
  logic drain;

  // in_ready comes straight from a flop, so out_ready never reaches upstream.
  assign in_ready  = !skid_v_q;
  assign accept    = in_valid && in_ready;
  assign drain     = main_v_q && out_ready;

  assign out_valid = main_v_q;
  assign out_ctrl  = main_v_q ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it
    // unassigned (which would infer a latch); blocking '=' is correct here.
    main_v_d    = main_v_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_v_d    = skid_v_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || drain) begin
      if (skid_v_q) begin
        // Skid beat is older than anything on the input: it goes first.
        main_v_d    = 1'b1;
        main_ctrl_d = skid_ctrl_q;
        main_data_d = skid_data_q;
        skid_v_d    = 1'b0;
      end else if (accept) begin
        main_v_d    = 1'b1;
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end else begin
        main_v_d    = 1'b0;
      end
    end else if (accept) begin
      skid_v_d    = 1'b1;
      skid_ctrl_d = in_ctrl;
      skid_data_d = in_data;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_v_q && !out_ready && !flush && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops sample the
  // pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      stall_cnt_q <= '0;
      // NOTE: payload registers are reset too, since out_data must read zero
      // while reset is held; this is not just a valid-bit clear.
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      stall_cnt_q <= stall_cnt_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, hand-written
// reset/saturation sequences, and random traffic against a 2-deep FIFO model.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int NW = 3;
  localparam int CW = 10;
  localparam int SW = 4;
  localparam int PW = NW * DW;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [PW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [PW-1:0] out_data;
  logic [SW-1:0] stall_cnt;

  pipe_stage_skid #(
    .DATA_WIDTH (DW),
    .DATA_WORDS (NW),
    .CTRL_WIDTH (CW),
    .STALL_CNT_W(SW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mkd(input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                                        input logic [DW-1:0] pc4);
    logic [PW-1:0] d;
    d = '0;
    d[WORD_ALU*DW   +: DW] = alu;
    d[WORD_WDATA*DW +: DW] = wd;
    d[WORD_PC4*DW   +: DW] = pc4;
    return d;
  endfunction

  // Reference model: the stage behaves as a FIFO of capacity two whose head is
  // presented downstream.
  typedef struct {
    logic [CW-1:0] ctrl;
    logic [PW-1:0] data;
  } beat_t;

  beat_t m_q[$];
  int    m_stall = 0;

  task automatic model_reset();
    m_q.delete();
    m_stall = 0;
  endtask

  task automatic model_check();
    check("m_in_ready",  {127'd0, in_ready},  {127'd0, (m_q.size() < 2)});
    check("m_out_valid", {127'd0, out_valid}, {127'd0, (m_q.size() > 0)});
    check("m_out_ctrl",  {118'd0, out_ctrl},  {118'd0, (m_q.size() > 0) ? m_q[0].ctrl : 10'd0});
    if (m_q.size() > 0) check("m_out_data", {32'd0, out_data}, {32'd0, m_q[0].data});
    check("m_stall_cnt", {124'd0, stall_cnt}, 128'(m_stall));
  endtask

  task automatic model_advance();
    bit    was_full;
    beat_t b;
    if (!rst_n) begin
      model_reset();
      return;
    end
    was_full = (m_q.size() == 2);
    if (m_q.size() > 0 && !out_ready && !flush && m_stall < SMAX) m_stall++;
    if (flush) begin
      m_q.delete();
      return;
    end
    if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
    if (in_valid && !was_full) begin
      b.ctrl = in_ctrl;
      b.data = in_data;
      m_q.push_back(b);
    end
  endtask

  // Inputs are stable from 1 after posedge; outputs are compared on negedge.
  task automatic step();
    @(negedge clk);
    model_check();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl,
                       input logic [CW-1:0] c, input logic [PW-1:0] d);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_ctrl   = c;
    in_data   = d;
  endtask

  typedef struct {
    logic          iv;
    logic          ordy;
    logic          fl;
    logic [CW-1:0] ctrl;
    logic [PW-1:0] data;
    logic          e_v;
    logic          e_rdy;
    logic [CW-1:0] e_ctrl;
    logic [PW-1:0] e_data;
    logic [SW-1:0] e_stall;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  initial begin
    logic [PW-1:0] d1, d2, da, db, dc, dj;
    d1 = mkd(32'h1, 32'h2, 32'h3);
    d2 = mkd(32'h4, 32'h5, 32'h6);
    da = mkd(32'hA0, 32'hA1, 32'hA2);
    db = mkd(32'hB0, 32'hB1, 32'hB2);
    dc = mkd(32'hC0, 32'hC1, 32'hC2);
    dj = mkd(32'hDEAD, 32'hBEEF, 32'hF00D);

    // inputs for one edge | outputs expected after that edge
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 10'h3FF, d1, 1'b1, 1'b1, 10'h3FF, d1, 4'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 10'h3FF, d2, 1'b1, 1'b1, 10'h3FF, d2, 4'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 10'h3FF, dj, 1'b0, 1'b1, 10'h000, '0, 4'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 10'h155, da, 1'b1, 1'b1, 10'h155, da, 4'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 10'h0AA, db, 1'b1, 1'b0, 10'h155, da, 4'd1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 10'h3FF, dj, 1'b1, 1'b0, 10'h155, da, 4'd2};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 10'h000, dj, 1'b1, 1'b1, 10'h0AA, db, 4'd2};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 10'h000, dj, 1'b0, 1'b1, 10'h000, '0, 4'd2};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 10'h101, da, 1'b1, 1'b1, 10'h101, da, 4'd2};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 10'h102, db, 1'b1, 1'b0, 10'h101, da, 4'd3};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 10'h3FF, dc, 1'b0, 1'b1, 10'h000, '0, 4'd3};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 10'h3FF, dc, 1'b0, 1'b1, 10'h000, '0, 4'd3};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 10'h3FF, dc, 1'b0, 1'b1, 10'h000, '0, 4'd3};

    drive(1'b0, 1'b1, 1'b0, '0, '0);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_in_ready",  {127'd0, in_ready},  128'd1);
    check("rst_out_ctrl",  {118'd0, out_ctrl},  128'd0);
    check("rst_out_data",  {32'd0, out_data},   128'd0);
    check("rst_stall_cnt", {124'd0, stall_cnt}, 128'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].ctrl, vecs[i].data);
      step();
      check($sformatf("vec%0d_out_valid", i), {127'd0, out_valid}, {127'd0, vecs[i].e_v});
      check($sformatf("vec%0d_in_ready", i),  {127'd0, in_ready},  {127'd0, vecs[i].e_rdy});
      check($sformatf("vec%0d_out_ctrl", i),  {118'd0, out_ctrl},  {118'd0, vecs[i].e_ctrl});
      if (vecs[i].e_v) check($sformatf("vec%0d_out_data", i), {32'd0, out_data}, {32'd0, vecs[i].e_data});
      check($sformatf("vec%0d_stall_cnt", i), {124'd0, stall_cnt}, {124'd0, vecs[i].e_stall});
    end

    // Async reset between edges while a beat is held downstream.
    drive(1'b1, 1'b0, 1'b0, 10'h3FF, d1);
    step();
    drive(1'b1, 1'b0, 1'b0, 10'h2AA, d2);
    step();
    check("pre_arst_out_valid", {127'd0, out_valid}, 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {127'd0, out_valid}, 128'd0);
    check("arst_out_ctrl",  {118'd0, out_ctrl},  128'd0);
    check("arst_stall_cnt", {124'd0, stall_cnt}, 128'd0);
    check("arst_in_ready",  {127'd0, in_ready},  128'd1);
    model_reset();
    drive(1'b0, 1'b1, 1'b0, 10'h3FF, '0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("post_arst_no_replay", {127'd0, out_valid}, 128'd0);

    // Stall counter saturation.
    drive(1'b1, 1'b1, 1'b0, 10'h0F0, d1);
    step();
    drive(1'b0, 1'b0, 1'b0, 10'h3FF, '0);
    repeat (20) step();
    check("sat_stall_cnt", {124'd0, stall_cnt}, 128'(SMAX));
    repeat (3) step();
    check("sat_hold_stall_cnt", {124'd0, stall_cnt}, 128'(SMAX));
    check("sat_out_ctrl", {118'd0, out_ctrl}, 128'h0F0);
    drive(1'b0, 1'b1, 1'b1, '0, '0);
    step();

    // Random traffic against the FIFO model.
    for (int n = 0; n < 2000; n++) begin
      drive(1'($urandom_range(0, 99) < 65),
            1'($urandom_range(0, 99) < 70),
            1'($urandom_range(0, 99) < 4),
            CW'($urandom),
            {DW'($urandom), DW'($urandom), DW'($urandom)});
      step();
    end
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
